fp_square: RTL
==============

Name: fp_square

Overview:
- Iterative single-precision floating-point squarer: res = op*op.
- Companion (inverse operation) to the FPU square-root unit; same start/done handshake, unpack/pack conventions and flag outputs, so the FPU issue logic drives both identically.
- Uses a radix-2 shift-add mantissa multiplier (one partial product per cycle) instead of a DSP multiply, to keep area low.
- Not pipelinable: one operation in flight.

Parameters:
DATA_W, 32, total float width (sign + exponent + stored mantissa)
EXP_W, 8, exponent width; BIAS = 2**(EXP_W-1)-1
(derived) MAN_W = DATA_W-EXP_W, mantissa width including hidden bit (24)
(derived) END_COUNT = MAN_W+3, cycles from start to done

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; latch op and begin operation
done  output  1  high when idle/result valid; low while busy
op  input  DATA_W  IEEE-754-style operand, sampled only when start=1
overflow  output  1  result exponent exceeded max finite; res = +inf
underflow  output  1  result below min normal; res flushed to +0
exception  output  1  op was Inf/NaN (exponent all ones)
res  output  DATA_W  squared result, valid while done=1

Behaviour:
- Reset (async): counter=END_COUNT (done=1); res=0; overflow=underflow=exception=0; datapath registers 0.
- Counter: start -> 0; else increments while counter != END_COUNT. done = (counter==END_COUNT). After start in cycle T, done=1 from cycle T+END_COUNT (27 cycles at defaults).
- start while busy: abort the current op, relatch op, restart the count; the old result is never presented.
- Cycle 1 (register on start):
  - Latch mantissa {1, op[MAN_W-2:0]} and exponent E.
  - Flags: zero_in = (E==0), which flushes denormals to zero; special_in = (E all ones).
  - Sign is discarded: the square is always non-negative.
- Cycles 2..MAN_W+1 (multiply):
  - Accumulator acc[2*MAN_W-1:0]. Low half initialised with the mantissa (multiplier), upper half 0.
  - Each cycle: if acc[0], add the mantissa (multiplicand) into the upper half with carry, then shift acc right by 1 as a (2*MAN_W+1)-bit value.
  - After MAN_W iterations acc = mant*mant, in [2^(2*MAN_W-2), 2^(2*MAN_W)).
- Normalize stage (registered):
  - norm = acc[2*MAN_W-1].
  - Stored mantissa = norm ? acc[2*MAN_W-2 -: MAN_W-1] : acc[2*MAN_W-3 -: MAN_W-1]. Truncation, no rounding, same as the square-root unit.
  - Exponent computed signed on EXP_W+2 bits: eb = 2*(E-BIAS) + norm + BIAS.
- Output stage (registered res and flags), priority:
  - special_in: res = {0, all-ones exponent, 0}, exception=1.
  - zero_in: res = 0, no flags.
  - eb >= 2**EXP_W-1: res = +inf, overflow=1.
  - eb <= 0: res = 0, underflow=1.
  - Otherwise res = {0, eb[EXP_W-1:0], mantissa}.
- Flags are mutually exclusive.
- res and flags hold stable while done=1 until the next op completes. During busy they keep their previous values and must not be used.
- No internal state depends on op after cycle 1; op may change freely while busy.

Test Plan:
- Reset mid-operation:
  - start op=0x40000000, assert rst at cycle 10 -> done=1 immediately, res=0, all flags 0.
  - Then start 0x40000000 -> res=0x40800000 (4.0).
- Latency and basic values:
  - 0x3FC00000 (1.5) -> done exactly 27 cycles after start, res=0x40100000 (2.25).
  - 0x40400000 (3.0) -> 0x41100000 (9.0).
- Sign handling:
  - 0xC0400000 (-3.0) -> 0x41100000, exception=0.
  - 0x3F800000 (1.0) -> 0x3F800000.
- Boundaries:
  - 0x7F000000 (2^127) -> res=0x7F800000, overflow=1.
  - 0x00800000 (2^-126) -> res=0, underflow=1.
  - 0x00000000 and denormal 0x00000001 -> res=0, no flags.
- Specials: 0x7F800000 (Inf) and 0x7FC00000 (NaN) -> res=0x7F800000, exception=1, overflow=underflow=0.
- Restart:
  - start 0x40400000, then at cycle 12 start 0x40000000 -> single done, 27 cycles after the second start, res=0x40800000.
  - Random sweep of 10k normal operands vs truncated reference model -> bit-exact match.

Source files
------------

// File: rtl/fp_square.sv
// Iterative single-precision squarer: res = op*op, radix-2 shift-add mantissa multiply.
// Shares the start/done handshake, unpack/pack rules and flag outputs of the sqrt unit.
module fp_square #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);
    localparam int MAN_W     = DATA_W - EXP_W;
    localparam int END_COUNT = MAN_W + 3;
    localparam int CNT_W     = $clog2(END_COUNT + 1);
    localparam int EB_W      = EXP_W + 2;

    localparam logic [CNT_W-1:0] C_NORM = CNT_W'(MAN_W);
    localparam logic [CNT_W-1:0] C_OUT  = CNT_W'(END_COUNT - 1);
    localparam logic [CNT_W-1:0] C_END  = CNT_W'(END_COUNT);

    localparam logic signed [EB_W-1:0] BIAS_V = EB_W'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EB_W-1:0] MAX_E  = EB_W'((2 ** EXP_W) - 1);

    logic [CNT_W-1:0]       count;
    logic [MAN_W-1:0]       mant;
    logic [EXP_W-1:0]       exp_q;
    logic                   zero_in;
    logic                   special_in;
    logic [2*MAN_W-1:0]     acc;
    logic [MAN_W-2:0]       man_n;
    logic signed [EB_W-1:0] eb_q;

    logic [MAN_W:0]         sum;
    logic                   norm;
    logic signed [EB_W-1:0] eb;
    logic [EXP_W-1:0]       op_exp;
    logic                   unused_sign;

    // Sign is irrelevant: a square is never negative.
    assign unused_sign = op[DATA_W-1];
    assign op_exp      = op[DATA_W-2 -: EXP_W];
    assign done        = (count == C_END);

    always_comb begin
        sum  = {1'b0, acc[2*MAN_W-1:MAN_W]} + (acc[0] ? {1'b0, mant} : '0);
        norm = acc[2*MAN_W-1];
        eb   = $signed({1'b0, exp_q, 1'b0})
             + $signed({{(EB_W-1){1'b0}}, norm})
             - BIAS_V;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= C_END;
            mant       <= '0;
            exp_q      <= '0;
            zero_in    <= 1'b0;
            special_in <= 1'b0;
            acc        <= '0;
            man_n      <= '0;
            eb_q       <= '0;
            res        <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            exception  <= 1'b0;
        end else if (start) begin
            count      <= '0;
            mant       <= {1'b1, op[MAN_W-2:0]};
            exp_q      <= op_exp;
            zero_in    <= (op_exp == '0);
            special_in <= (op_exp == '1);
            acc        <= {{MAN_W{1'b0}}, 1'b1, op[MAN_W-2:0]};
        end else if (count != C_END) begin
            count <= count + 1'b1;
            if (count < C_NORM)
                acc <= {sum, acc[MAN_W-1:1]};
            if (count == C_NORM) begin
                man_n <= norm ? acc[2*MAN_W-2 -: MAN_W-1]
                              : acc[2*MAN_W-3 -: MAN_W-1];
                eb_q  <= eb;
            end
            if (count == C_OUT) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                exception <= 1'b0;
                if (special_in) begin
                    res       <= {1'b0, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
                    exception <= 1'b1;
                end else if (zero_in) begin
                    res <= '0;
                end else if (eb_q >= MAX_E) begin
                    res      <= {1'b0, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
                    overflow <= 1'b1;
                end else if (eb_q <= 0) begin
                    res       <= '0;
                    underflow <= 1'b1;
                end else begin
                    res <= {1'b0, eb_q[EXP_W-1:0], man_n};
                end
            end
        end
    end
endmodule
